// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer states, phase constants and state decode helper.
//   state_t     : IDLE, RUN, STEP, HALTED
//   NUM_PHASES_DEF / PHASE_W_DEF / LAST_PHASE : default phase geometry
//   is_active() : 1 for the states in which phases advance
package cpu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    localparam int NUM_PHASES_DEF = 5;
    localparam int PHASE_W_DEF    = 3;
    localparam int LAST_PHASE     = NUM_PHASES_DEF - 1;

    function automatic logic is_active(input state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/button_sync.sv
// button_sync: synchronizes an asynchronous pushbutton level and emits one registered
// 1-cycle pulse per rising edge, SYNC_STAGES+1 cycles after the edge.
//   clock, reset : system clock, synchronous active-high reset
//   async_in     : raw button level
//   pulse        : registered rising-edge pulse
module button_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], async_in};
            prev  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: generates the instruction phase number and owns run/stop/step/halt state.
//   clock, reset : system clock, synchronous active-high reset
//   exec, step   : asynchronous pushbuttons (run/stop toggle, single instruction)
//   halt         : decoder halt request, honoured only in the last phase
//   phase        : current phase, 0..NUM_PHASES-1
//   running      : RUN or STEP; halted : HALTED
//   instr_done   : 1-cycle pulse after each retired instruction
//   instr_count  : retired instructions since reset, wrapping
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES  = NUM_PHASES_DEF,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic               step,
    input  logic               halt,
    output logic [PHASE_W-1:0] phase,
    output logic               running,
    output logic               halted,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W:0]   LIMIT = (PHASE_W + 1)'(NUM_PHASES);

    state_t             state, state_n;
    logic [PHASE_W-1:0] phase_n;
    logic [CNT_W-1:0]   count_n;
    logic               stop_req, stop_n, done_n;
    logic               exec_pulse, step_pulse;
    logic               phase_bad;

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (exec),
        .pulse    (exec_pulse)
    );

    button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (step),
        .pulse    (step_pulse)
    );

    // Out-of-range phase (e.g. after an upset) is recovered to 0 without retiring.
    assign phase_bad = {1'b0, phase} >= LIMIT;

    assign running = is_active(state);
    assign halted  = (state == HALTED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            stop_req    <= 1'b0;
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            stop_req    <= stop_n;
            instr_done  <= done_n;
            instr_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        stop_n  = stop_req;
        done_n  = 1'b0;
        count_n = instr_count;
        case (state)
            IDLE: begin
                phase_n = '0;
                state_n = exec_pulse ? RUN : step_pulse ? STEP : IDLE;
            end
            RUN, STEP: begin
                if (phase_bad) begin
                    phase_n = '0;
                end else if (phase == LAST) begin
                    done_n  = 1'b1;
                    count_n = instr_count + CNT_W'(1);
                    phase_n = '0;
                    state_n = halt ? HALTED : (state == STEP || stop_req) ? IDLE : RUN;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
                // Stop requests collect during RUN and die with the RUN state.
                stop_n = (state_n != RUN) ? 1'b0 : stop_req | ((state == RUN) & exec_pulse);
            end
            HALTED: begin
                phase_n = '0;
                stop_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
                stop_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized scoreboard bench for phase_sequencer against a cycle reference model.
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int PW = 3;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          exec  = 1'b0;
    logic          step  = 1'b0;
    logic          halt  = 1'b0;
    logic [PW-1:0] phase;
    logic          running, halted, instr_done;
    logic [CW-1:0] instr_count;

    phase_sequencer #(.NUM_PHASES(NP), .PHASE_W(PW), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step        (step),
        .halt        (halt),
        .phase       (phase),
        .running     (running),
        .halted      (halted),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int phase;
        bit running;
        bit halted;
        bit done;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   ret_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   model_wrap = 0;
    bit   dut_wrap = 0;

    // Reference model: modes 0=idle 1=run 2=step 3=halted.
    int       m_mode = 0, m_phase = 0, m_cnt = 0;
    bit       m_stop = 0, m_done = 0;
    bit [3:0] eh = '0, sh = '0;

    always @(posedge clock) begin
        bit ep, sp, last;
        exp_t e;
        if (reset) begin
            m_mode = 0; m_phase = 0; m_cnt = 0; m_stop = 0; m_done = 0;
            eh = '0; sh = '0;
        end else begin
            // A button edge is seen by the sequencer three sampled cycles later.
            ep = eh[2] & ~eh[3];
            sp = sh[2] & ~sh[3];
            eh = {eh[2:0], exec};
            sh = {sh[2:0], step};
            m_done = 0;
            if (m_mode == 0) begin
                m_mode = ep ? 1 : sp ? 2 : 0;
            end else if (m_mode == 1 || m_mode == 2) begin
                last = (m_phase == NP - 1);
                if (last) begin
                    m_done = 1;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    if (m_cnt == 0) model_wrap = 1;
                    ret_q.push_back(m_cnt);
                    m_phase = 0;
                    if (halt) begin
                        m_mode = 3; m_stop = 0;
                    end else if (m_mode == 2 || m_stop) begin
                        m_mode = 0; m_stop = 0;
                    end else begin
                        m_stop = ep;
                    end
                end else begin
                    m_phase = m_phase + 1;
                    if (m_mode == 1 && ep) m_stop = 1;
                end
            end
        end
        e.phase = m_phase;
        e.running = (m_mode == 1 || m_mode == 2);
        e.halted = (m_mode == 3);
        e.done = m_done;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    end

    always @(negedge clock) begin
        exp_t e;
        int   r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (int'(phase) != e.phase || running != e.running || halted != e.halted ||
                instr_done != e.done || int'(instr_count) != e.cnt) begin
                fails++;
                $display("FAIL cycle_state t=%0t got phase=%0d run=%0b halt=%0b done=%0b cnt=%0d expected phase=%0d run=%0b halt=%0b done=%0b cnt=%0d",
                         $time, phase, running, halted, instr_done, instr_count,
                         e.phase, e.running, e.halted, e.done, e.cnt);
            end
        end
        if (instr_done === 1'b1) begin
            if (instr_count == '0) dut_wrap = 1;
            tests++;
            if (ret_q.size() == 0) begin
                fails++;
                $display("FAIL retire_extra t=%0t got instr_done with count=%0d expected no retirement", $time, instr_count);
            end else begin
                r = ret_q.pop_front();
                if (int'(instr_count) != r) begin
                    fails++;
                    $display("FAIL retire_count t=%0t got %0d expected %0d", $time, instr_count, r);
                end
            end
        end
    end

    task automatic rand_cycles(input int n, input int halt_inv, input int rst_inv);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exec  = exec ? ($urandom_range(5) != 0) : ($urandom_range(24) == 0);
            step  = step ? ($urandom_range(5) != 0) : ($urandom_range(24) == 0);
            halt  = (halt_inv != 0) && ($urandom_range(halt_inv - 1) == 0);
            reset = (rst_inv != 0) && ($urandom_range(rst_inv - 1) == 0);
        end
    endtask

    task automatic hold_cycles(input int n, input bit e, input bit s, input bit h, input bit r);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exec = e; step = s; halt = h; reset = r;
        end
    endtask

    initial begin
        hold_cycles(3, 0, 0, 0, 1);
        hold_cycles(1, 0, 0, 0, 0);
        // Start once, then free-run long enough for the retired counter to wrap.
        hold_cycles(3, 1, 0, 0, 0);
        hold_cycles(1400, 0, 0, 0, 0);
        // Stop request, then a single step with a second step press during the sweep.
        hold_cycles(2, 1, 0, 0, 0);
        hold_cycles(12, 0, 0, 0, 0);
        hold_cycles(2, 0, 1, 0, 0);
        hold_cycles(4, 0, 0, 0, 0);
        hold_cycles(2, 0, 1, 0, 0);
        hold_cycles(12, 0, 0, 0, 0);
        // Exec held for 100 cycles must toggle state only once.
        hold_cycles(2, 0, 0, 0, 1);
        hold_cycles(100, 1, 0, 0, 0);
        hold_cycles(20, 0, 0, 0, 0);
        // Halt held constantly: taken at the next last phase, then buttons are inert.
        hold_cycles(12, 0, 0, 1, 0);
        hold_cycles(3, 1, 0, 0, 0);
        hold_cycles(6, 0, 1, 0, 0);
        hold_cycles(8, 0, 0, 0, 0);
        hold_cycles(2, 0, 0, 0, 1);
        for (int ep_i = 0; ep_i < 30; ep_i++) begin
            hold_cycles(2, 0, 0, 0, 1);
            rand_cycles(150, (ep_i % 3 == 0) ? 0 : 12, (ep_i % 2 == 0) ? 0 : 97);
        end
        hold_cycles(4, 0, 0, 0, 0);
        tests++;
        if (dut_wrap != model_wrap || !model_wrap) begin
            fails++;
            $display("FAIL count_wrap got wrap_seen=%0b expected %0b", dut_wrap, 1'b1);
        end
        tests++;
        if (ret_q.size() != 0) begin
            fails++;
            $display("FAIL retire_missing got %0d unretired expected 0", ret_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
